fifo_level_flags: RTL
=====================

Name: fifo_level_flags

Overview:
Registered, parametrised FIFO status generator and successor to the fixed almost-empty comparator. It derives occupancy from wrap-bit read/write pointers and produces empty, full, almost-empty and almost-full flags. Thresholds are run-time programmable, and the almost flags have hysteresis. Sticky overflow, underflow, pointer and config error flags are included. It sits beside the FIFO memory/pointer logic in the same clock domain.

Parameters:
ADDR_W, 4, address bits; DEPTH = 2**ADDR_W (derived, not overridable)
AE_INIT, 2, almost-empty threshold after reset
AF_INIT, 14, almost-full threshold after reset
HYST, 1, hysteresis band in entries; legal when AE_INIT+HYST < AF_INIT-HYST and AF_INIT <= DEPTH

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous reset, active-high
w_pointer  in  ADDR_W+1  write pointer incl. wrap bit
r_pointer  in  ADDR_W+1  read pointer incl. wrap bit
push  in  1  write request this cycle
pop  in  1  read request this cycle
cfg_we  in  1  threshold write strobe
cfg_sel  in  1  0 = AE threshold, 1 = AF threshold
cfg_data  in  ADDR_W+1  threshold value
err_clr  in  1  clears all sticky errors
level  out  ADDR_W+1  registered occupancy
empty  out  1  level == 0
full  out  1  level == DEPTH
ae_flag  out  1  almost empty
af_flag  out  1  almost full
ovf_err  out  1  sticky: push while full
udf_err  out  1  sticky: pop while empty
ptr_err  out  1  sticky: pointer difference > DEPTH
cfg_err  out  1  sticky: rejected threshold write

Behaviour:
- Reset (priority over all inputs, any cycle, mid-operation included): level=0, empty=1, full=0, ae_flag=1, af_flag=0, all errors=0, ae_thr=AE_INIT, af_thr=AF_INIT.
- Raw level: raw = (w_pointer - r_pointer) mod 2**(ADDR_W+1). Wrap handled by modular subtraction.
- If raw > DEPTH: ptr_err is set, level saturates to DEPTH, full=1.
- Latency: all outputs are registered. Pointers sampled at edge N are reflected at edge N+1, i.e. 1 cycle.
- empty/full are computed from the next level value.
- ae_flag:
  - sets when next level <= ae_thr;
  - clears when next level > ae_thr+HYST;
  - otherwise holds.
- af_flag:
  - sets when next level >= af_thr;
  - clears when next level < af_thr-HYST;
  - otherwise holds.
- Hysteresis comparisons use ADDR_W+2-bit arithmetic; af_thr-HYST saturates at 0.
- Threshold write (cfg_we=1) is rejected and sets cfg_err if any of these hold:
  - cfg_data > DEPTH;
  - the write would give ae_thr+HYST >= af_thr-HYST.
  A rejected write leaves both thresholds unchanged. An accepted write takes effect for flag evaluation from the next cycle; the write cycle uses the old thresholds.
- ovf_err sets on push && full && !pop, using the registered full flag.
- udf_err sets on pop && empty, using the registered empty flag.
- err_clr clears all four error flags. A new error condition in the same cycle as err_clr wins: the flag stays 1.
- Errors never affect level or thresholds.

Test Plan:
(ADDR_W=4, DEPTH=16, AE_INIT=2, AF_INIT=14, HYST=1)
1. Reset: hold rst 2 cycles with w=5, r=3 -> all outputs at reset values during reset. First edge after release: level=2, ae_flag=1, empty=0.
2. Fill sweep: r=0, w steps 0..16 one per cycle -> level follows w one cycle late; ae_flag clears at level 4; af_flag sets at level 14; full=1 at level 16. Drain back to 0 -> af_flag clears at 12, ae_flag sets at 2, empty=1 at 0.
3. Wrap-around: w=5'b00010, r=5'b11110 -> level=4. Then w=5'b10000, r=5'b00000 -> level=16, full=1, ptr_err=0.
4. Config: write cfg_sel=0, data=6 -> at level 5 ae_flag=1 next cycle. Then cfg_sel=1, data=4 -> rejected, cfg_err=1, af_thr remains 14. Assert err_clr -> cfg_err=0.
5. Errors:
   - push=1, pop=0 while full -> ovf_err=1 next cycle and stays set.
   - err_clr together with push at full -> ovf_err stays 1.
   - pop while empty -> udf_err=1.
   - w=20, r=0 -> ptr_err=1, level=16, full=1.
6. Reset mid-fill at level 9 with af/ae programmed to 10/4 -> next cycle level=0, thresholds back to 2/14, errors cleared.

Source files
------------

// File: rtl/fifo_level_flags.sv
// FIFO occupancy and status flags derived from wrap-bit pointers, with
// programmable almost-empty/almost-full thresholds, hysteresis and sticky error flags.
module fifo_level_flags #(
    parameter int ADDR_W  = 4,
    parameter int AE_INIT = 2,
    parameter int AF_INIT = 14,
    parameter int HYST    = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W:0]   w_pointer,
    input  logic [ADDR_W:0]   r_pointer,
    input  logic              push,
    input  logic              pop,
    input  logic              cfg_we,
    input  logic              cfg_sel,
    input  logic [ADDR_W:0]   cfg_data,
    input  logic              err_clr,
    output logic [ADDR_W:0]   level,
    output logic              empty,
    output logic              full,
    output logic              ae_flag,
    output logic              af_flag,
    output logic              ovf_err,
    output logic              udf_err,
    output logic              ptr_err,
    output logic              cfg_err
);
    localparam int DEPTH = 2 ** ADDR_W;
    localparam int PW    = ADDR_W + 1;
    localparam int XW    = ADDR_W + 2;

    logic [PW-1:0] ae_thr, af_thr;
    logic [PW-1:0] raw, level_nxt;
    logic          ptr_bad;
    logic [XW-1:0] lvl_x, ae_hi, af_lo;
    logic          ae_nxt, af_nxt;
    logic [PW-1:0] cand_ae, cand_af;
    logic [XW-1:0] cand_ae_hi, cand_af_lo;
    logic          cfg_bad;
    logic          ovf_set, udf_set;

    // Modular subtraction on the wrap-bit pointers gives occupancy directly.
    assign raw       = w_pointer - r_pointer;
    assign ptr_bad   = raw > PW'(DEPTH);
    assign level_nxt = ptr_bad ? PW'(DEPTH) : raw;

    // Hysteresis bounds are one bit wider so ae_thr+HYST cannot wrap.
    assign lvl_x = {1'b0, level_nxt};
    assign ae_hi = {1'b0, ae_thr} + XW'(HYST);
    assign af_lo = ({1'b0, af_thr} >= XW'(HYST)) ? {1'b0, af_thr} - XW'(HYST) : '0;

    always_comb begin
        ae_nxt = ae_flag;
        if (lvl_x <= {1'b0, ae_thr})
            ae_nxt = 1'b1;
        else if (lvl_x > ae_hi)
            ae_nxt = 1'b0;

        af_nxt = af_flag;
        if (lvl_x >= {1'b0, af_thr})
            af_nxt = 1'b1;
        else if (lvl_x < af_lo)
            af_nxt = 1'b0;
    end

    // Validate the threshold pair as it would look after the write.
    always_comb begin
        cand_ae    = cfg_sel ? ae_thr : cfg_data;
        cand_af    = cfg_sel ? cfg_data : af_thr;
        cand_ae_hi = {1'b0, cand_ae} + XW'(HYST);
        cand_af_lo = ({1'b0, cand_af} >= XW'(HYST)) ? {1'b0, cand_af} - XW'(HYST) : '0;
        cfg_bad    = (cfg_data > PW'(DEPTH)) || (cand_ae_hi >= cand_af_lo);
    end

    assign ovf_set = push && full && !pop;
    assign udf_set = pop && empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            level   <= '0;
            empty   <= 1'b1;
            full    <= 1'b0;
            ae_flag <= 1'b1;
            af_flag <= 1'b0;
            ovf_err <= 1'b0;
            udf_err <= 1'b0;
            ptr_err <= 1'b0;
            cfg_err <= 1'b0;
            ae_thr  <= PW'(AE_INIT);
            af_thr  <= PW'(AF_INIT);
        end else begin
            level   <= level_nxt;
            empty   <= (level_nxt == '0);
            full    <= (level_nxt == PW'(DEPTH));
            ae_flag <= ae_nxt;
            af_flag <= af_nxt;
            // A fresh error in the clear cycle keeps the flag set.
            ovf_err <= ovf_set              || (ovf_err && !err_clr);
            udf_err <= udf_set              || (udf_err && !err_clr);
            ptr_err <= ptr_bad              || (ptr_err && !err_clr);
            cfg_err <= (cfg_we && cfg_bad)  || (cfg_err && !err_clr);
            if (cfg_we && !cfg_bad) begin
                if (cfg_sel)
                    af_thr <= cfg_data;
                else
                    ae_thr <= cfg_data;
            end
        end
    end
endmodule
